// File: rtl/apb_master.sv
// Single-outstanding APB3 requester: valid/ready command in, valid/ready response out.
// Optional transfer/error counters are enabled with `define APB_MASTER_STATS_EN.
module apb_master #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int unsigned       TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0] TO_RDATA       = '0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
`ifdef APB_MASTER_STATS_EN
  ,
  output logic [31:0]       stat_xfers,
  output logic [31:0]       stat_errs
`endif
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              cmd_ready_d, psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rdata_d;
  logic              rvalid_d, rerr_d, rto_d;
  logic [31:0]       wd_cnt, wd_d;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    rvalid_d    = rsp_valid;
    rdata_d     = rsp_rdata;
    rerr_d      = rsp_err;
    rto_d       = rsp_timeout;
    wd_d        = wd_cnt;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d     = SETUP;
        cmd_ready_d = 1'b0;
        psel_d      = 1'b1;
        penable_d   = 1'b0;
        pwrite_d    = cmd_write;
        paddr_d     = cmd_addr;
        pwdata_d    = cmd_write ? cmd_wdata : '0;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // PREADY takes priority over a watchdog expiry on the same edge
        if (PREADY) begin
          state_d   = RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = PWRITE ? '0 : PRDATA;
          rerr_d    = PSLVERR;
          rto_d     = 1'b0;
        end else begin
          wd_d = wd_cnt + 32'd1;
          if (TIMEOUT_CYCLES != 0 && wd_d == TIMEOUT_CYCLES) begin
            state_d   = RESP;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            rvalid_d  = 1'b1;
            rdata_d   = TO_RDATA;
            rerr_d    = 1'b1;
            rto_d     = 1'b1;
          end
        end
      end
      RESP: if (rsp_ready) begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        rvalid_d    = 1'b0;
        wd_d        = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cmd_ready   <= 1'b1;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready   <= cmd_ready_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      rsp_valid   <= rvalid_d;
      rsp_rdata   <= rdata_d;
      rsp_err     <= rerr_d;
      rsp_timeout <= rto_d;
      wd_cnt      <= wd_d;
    end
  end

`ifdef APB_MASTER_STATS_EN
  // Saturating counters, one step per response handshake
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      stat_xfers <= '0;
      stat_errs  <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (stat_xfers != 32'hFFFF_FFFF) stat_xfers <= stat_xfers + 32'd1;
      if (rsp_err && stat_errs != 32'hFFFF_FFFF) stat_errs <= stat_errs + 32'd1;
    end
  end
`endif

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-outstanding APB3 requester that drives the register-file slave (accumulator/mask/control/result map).
- Converts a valid/ready command channel into APB SETUP/ACCESS phases.
- Returns read data and error status on a valid/ready response channel.
- Includes a PREADY watchdog so a hung slave cannot stall the command source.

Parameters:
- ADDR_W, 32, PADDR/cmd_addr width.
- DATA_W, 32, PWDATA/PRDATA width.
- TIMEOUT_CYCLES, 64, max ACCESS cycles with PREADY=0 before abort; 0 disables the watchdog.
- TO_RDATA, 32'h0000_0000, rsp_rdata value returned on a watchdog abort.

Ports:
- PCLK  in  1  clock
- PRESET  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when cmd_valid=1
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_err  out  1  PSLVERR captured, or watchdog abort
- rsp_timeout  out  1  response caused by watchdog abort
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Clocking and reset: one clock, PCLK; reset is synchronous and active-high (PRESET). All outputs are registered.
- Reset: state=IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the watchdog count all = 0. cmd_ready=1 from the first cycle after reset is released.
- Reset mid-transfer: PSEL/PENABLE drop on the next edge. No response is produced for the aborted command.
- FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch write/addr/wdata and go to SETUP.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0; PADDR/PWRITE/PWDATA = latched command. PWDATA=0 for reads.
- ACCESS: PSEL=1, PENABLE=1, address/data held stable.
  - On an edge with PREADY=1: capture PRDATA (reads only; writes return 0) and PSLVERR into rsp_rdata/rsp_err; drop PSEL/PENABLE; go to RESP.
  - On an edge with PREADY=0: increment the watchdog count.
  - Watchdog abort: when the count reaches TIMEOUT_CYCLES (non-zero) with PREADY still 0, rsp_err=1, rsp_timeout=1, rsp_rdata=TO_RDATA; drop PSEL/PENABLE; go to RESP.
  - If PREADY=1 arrives on the same edge the count would reach the limit, PREADY wins: normal completion.
- RESP: rsp_valid=1, payload held stable until rsp_ready. On rsp_valid&rsp_ready go to IDLE, rsp_valid=0, clear the watchdog count.
- cmd_ready=0 in SETUP/ACCESS/RESP. No new command is accepted until the response is consumed.
- PREADY/PSLVERR/PRDATA are ignored outside ACCESS. A stale PREADY in IDLE or SETUP has no effect.
- Latency:
  - Accept edge N: SETUP during cycle N+1, ACCESS from N+2.
  - Zero-wait slave: rsp_valid from cycle N+3.
  - One-wait slave: rsp_valid from cycle N+4.
  - Back-to-back issue with rsp_ready tied 1: 4 cycles per zero-wait transfer, IDLE lasting 1 cycle.
- PSEL never asserts without a SETUP cycle first. PENABLE=1 only while PSEL=1.

Optional Feature:
- Macro: APB_MASTER_STATS_EN.
- When defined:
  - Adds outputs stat_xfers (32) and stat_errs (32), both reset to 0.
  - stat_xfers increments once per response handshake.
  - stat_errs increments when that response has rsp_err=1.
  - Both counters saturate at 32'hFFFF_FFFF.
- When undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Test Plan:
- Write 0x0=5, write 0x4=0xFFFF_FFFF, write 0x8=1, read 0xC -> rsp_rdata=5, rsp_err=0; every APB transfer has exactly one SETUP cycle.
- Write 0x0=3, write 0x8=1, read 0xC (result previously 5) -> rsp_rdata=6; write 0x8=2, read 0xC -> 0.
- Write 0xC=7 -> rsp_err=1, rsp_timeout=0. Read 0x10 -> rsp_err=1, rsp_rdata=0xDEAD_BEEF.
- PREADY tied 0, TIMEOUT_CYCLES=16, read 0x4 -> response 16 ACCESS cycles after entering ACCESS, with rsp_err=1, rsp_timeout=1, rsp_rdata=0, and PSEL=0 in RESP.
- Hold rsp_ready=0 for 10 cycles -> rsp_valid and payload stable, cmd_ready=0, no APB activity; release -> next command is accepted one cycle later.
- Assert PRESET during ACCESS -> next edge: PSEL=PENABLE=rsp_valid=0, cmd_ready=1 after release; stats counters (if enabled) = 0.
